// File: rtl/rv151_uart_mmio.sv
// rv151_uart_mmio: memory-mapped UART peripheral for the RV151 core data port.
// Four word registers live in a 16-byte window at BASE_ADDR:
//   +0x0 RXDATA (R)  received byte
//   +0x4 TXDATA (W)  push into 4-entry TX FIFO
//   +0x8 STATUS (R/W1C) {tx_drop, rx_frame_err, rx_overrun, rx_valid, tx_empty, tx_full}
//   +0xC CTRL   (R/W) {loopback, tx_ie, rx_ie}
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   md_en/ad/we/wd     core data-port access (md_we==0 is a read)
//   md_rd              registered read data, one-cycle latency
//   uart_rx, uart_tx   8N1 serial lines, idle high
//   irq                (rx_ie & rx_valid) | (tx_ie & tx_empty)
module rv151_uart_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        md_en,
   input  logic [31:0] md_ad,
   input  logic [3:0]  md_we,
   input  logic [31:0] md_wd,
   output logic [31:0] md_rd,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- bus decode ----------------
   logic       sel, rd_acc, wr_acc;
   logic [1:0] off;

   assign sel    = md_en && (md_ad[31:4] == BASE_ADDR[31:4]);
   assign off    = md_ad[3:2];
   assign rd_acc = sel && (md_we == 4'b0000);
   assign wr_acc = sel && md_we[0];

   logic unused_bits;
   assign unused_bits = ^{md_ad[1:0], md_wd[31:8]};

   // ---------------- registers ----------------
   logic [2:0] ctrl;
   logic [7:0] rx_byte;
   logic       rx_valid, rx_overrun, rx_frame_err, tx_drop;

   // ---------------- TX FIFO ----------------
   logic [7:0] tx_mem [4];
   logic [1:0] tx_wp, tx_rp;
   logic [2:0] tx_cnt;
   logic       tx_full, tx_push_req, tx_push, tx_pop, tx_empty;

   tx_state_t  tx_state;
   logic [CW-1:0] tx_tick;
   logic [2:0] tx_bitn;
   logic [7:0] tx_shift;
   logic       tx_bit_end;

   assign tx_full     = (tx_cnt == 3'd4);
   assign tx_push_req = wr_acc && (off == 2'd1);
   // A full FIFO refuses the push even when a pop happens the same cycle.
   assign tx_push     = tx_push_req && !tx_full;
   assign tx_bit_end  = (tx_tick == BIT_LAST);
   assign tx_pop      = (tx_cnt != 3'd0) &&
                        ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));
   assign tx_empty    = (tx_cnt == 3'd0) && (tx_state == TX_IDLE);

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= md_wd[7:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 2'd1;
         if (tx_pop)  tx_rp <= tx_rp + 2'd1;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + 3'd1;
            2'b01:   tx_cnt <= tx_cnt - 3'd1;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state <= TX_IDLE;
         tx_tick  <= '0;
         tx_bitn  <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_tick <= '0;
               tx_bitn <= '0;
               if (tx_pop) begin
                  tx_shift <= tx_mem[tx_rp];
                  uart_tx  <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_tick  <= '0;
                  uart_tx  <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_tick <= tx_tick + CW'(1);
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_tick <= '0;
                  if (tx_bitn == 3'd7) begin
                     tx_bitn  <= '0;
                     uart_tx  <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bitn  <= tx_bitn + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     uart_tx  <= tx_shift[1];
                  end
               end else begin
                  tx_tick <= tx_tick + CW'(1);
               end
            end
            TX_STOP: begin
               if (tx_bit_end) begin
                  tx_tick <= '0;
                  // Chain straight into the next start bit when data is waiting.
                  if (tx_pop) begin
                     tx_shift <= tx_mem[tx_rp];
                     uart_tx  <= 1'b0;
                     tx_state <= TX_START;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_tick <= tx_tick + CW'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- RX synchronizer and FSM ----------------
   logic rx_in, rx_s1, rx_s2;
   assign rx_in = ctrl[2] ? uart_tx : uart_rx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx_in;
         rx_s2 <= rx_s1;
      end
   end

   rx_state_t     rx_state;
   logic [CW-1:0] rx_tick;
   logic [2:0]    rx_bitn;
   logic [7:0]    rx_shift;
   logic          rx_stop_smp, rx_load, rx_set_ovr, rx_set_ferr;

   assign rx_stop_smp = (rx_state == RX_STOP) && (rx_tick == BIT_LAST);
   assign rx_set_ferr = rx_stop_smp && !rx_s2;
   assign rx_set_ovr  = rx_stop_smp &&  rx_s2 &&  rx_valid;
   assign rx_load     = rx_stop_smp &&  rx_s2 && !rx_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_state <= RX_IDLE;
         rx_tick  <= '0;
         rx_bitn  <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               rx_tick <= '0;
               rx_bitn <= '0;
               if (!rx_s2) rx_state <= RX_START;
            end
            RX_START: begin
               // Mid-start-bit check; a high line here means it was a glitch.
               if (rx_tick == HALF_LAST) begin
                  rx_tick  <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tick <= rx_tick + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_tick == BIT_LAST) begin
                  rx_tick  <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bitn == 3'd7) begin
                     rx_bitn  <= '0;
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bitn <= rx_bitn + 3'd1;
                  end
               end else begin
                  rx_tick <= rx_tick + CW'(1);
               end
            end
            RX_STOP: begin
               if (rx_tick == BIT_LAST) begin
                  rx_tick  <= '0;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_tick <= rx_tick + CW'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- STATUS / CTRL / RXDATA ----------------
   logic [3:0] clr;
   assign clr = (wr_acc && (off == 2'd2)) ? md_wd[5:2] : 4'b0000;

   // Set terms are OR-ed after the clear mask so a same-cycle event wins.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
         tx_drop      <= 1'b0;
         rx_byte      <= '0;
         ctrl         <= '0;
      end else begin
         rx_valid     <= (rx_valid     & ~clr[0]) | rx_load;
         rx_overrun   <= (rx_overrun   & ~clr[1]) | rx_set_ovr;
         rx_frame_err <= (rx_frame_err & ~clr[2]) | rx_set_ferr;
         tx_drop      <= (tx_drop      & ~clr[3]) | (tx_push_req && tx_full);
         if (rx_load) rx_byte <= rx_shift;
         if (wr_acc && (off == 2'd3)) ctrl <= md_wd[2:0];
      end
   end

   // ---------------- read path ----------------
   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      case (off)
         2'd0:    rd_mux = {24'h0, rx_byte};
         2'd2:    rd_mux = {26'h0, tx_drop, rx_frame_err, rx_overrun, rx_valid, tx_empty, tx_full};
         2'd3:    rd_mux = {29'h0, ctrl};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       md_rd <= '0;
      else if (rd_acc) md_rd <= rd_mux;
   end

   assign irq = (ctrl[0] & rx_valid) | (ctrl[1] & tx_empty);

endmodule

// File: tb/tb_rv151_uart_mmio.sv
// Scoreboard bench for rv151_uart_mmio with CLKS_PER_BIT=8.
module tb_rv151_uart_mmio;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int unsigned CPB  = 8;
   localparam logic [31:0] A_RX = BASE + 32'h0;
   localparam logic [31:0] A_TX = BASE + 32'h4;
   localparam logic [31:0] A_ST = BASE + 32'h8;
   localparam logic [31:0] A_CT = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rstn;
   logic        md_en;
   logic [31:0] md_ad;
   logic [3:0]  md_we;
   logic [31:0] md_wd;
   logic [31:0] md_rd;
   logic        uart_rx;
   logic        uart_tx;
   logic        irq;

   rv151_uart_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rstn), .md_en(md_en), .md_ad(md_ad), .md_we(md_we),
      .md_wd(md_wd), .md_rd(md_rd), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;
   int cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // read scoreboard
   logic [31:0] rd_exp_q [$];
   string       rd_nm_q  [$];
   logic        rd_seen;

   // TX frame scoreboard: {gap_free, byte}
   logic [8:0]  tx_exp_q [$];
   logic        mon_busy = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) rd_seen <= 1'b0;
      else       rd_seen <= md_en && (md_we == 4'b0000) && (md_ad[31:4] == BASE[31:4]);
   end

   // read monitor
   initial begin : rd_mon
      logic [31:0] e;
      string n;
      forever begin
         @(negedge clk);
         if (rd_seen) begin
            vec++;
            if (rd_exp_q.size() == 0) begin
               miss++;
               $display("FAIL rd_unexpected: md_rd=%h with no expected value", md_rd);
            end else begin
               e = rd_exp_q.pop_front();
               n = rd_nm_q.pop_front();
               if (md_rd !== e) begin
                  miss++;
                  $display("FAIL %s: md_rd=%h expected %h", n, md_rd, e);
               end
            end
         end
      end
   end

   // serial TX monitor
   initial begin : tx_mon
      logic [79:0] smp;
      logic        aborted, shape_ok;
      logic [7:0]  got;
      logic [8:0]  e;
      int          start_cyc;
      int          last_end = -1000;
      forever begin
         @(negedge clk);
         if (rstn && uart_tx === 1'b0) begin
            mon_busy  = 1'b1;
            start_cyc = cyc;
            smp       = '0;
            aborted   = 1'b0;
            for (int i = 1; i < 80; i++) begin
               @(negedge clk);
               if (!rstn) aborted = 1'b1;
               smp[i] = uart_tx;
            end
            if (!aborted) begin
               shape_ok = (smp[0] == 1'b0) && (smp[72] == 1'b1);
               for (int b = 0; b < 10; b++)
                  for (int k = 0; k < 8; k++)
                     if (smp[8*b+k] !== smp[8*b]) shape_ok = 1'b0;
               for (int b = 0; b < 8; b++) got[b] = smp[8*(b+1)];
               vec++;
               if (tx_exp_q.size() == 0) begin
                  miss++;
                  $display("FAIL tx_unexpected: frame byte %h", got);
               end else begin
                  e = tx_exp_q.pop_front();
                  if (!shape_ok || got !== e[7:0] || (e[8] && start_cyc != last_end + 1)) begin
                     miss++;
                     $display("FAIL tx_frame: byte %h shape_ok %0d gap %0d, expected byte %h gap_free %0d",
                              got, shape_ok, start_cyc - last_end - 1, e[7:0], e[8]);
                  end
               end
               last_end = cyc;
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      md_en = 1'b1; md_ad = a; md_we = we; md_wd = d;
      @(posedge clk); #1;
      md_en = 1'b0; md_we = 4'b0000; md_wd = '0;
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string n);
      rd_exp_q.push_back(e);
      rd_nm_q.push_back(n);
      md_en = 1'b1; md_ad = a; md_we = 4'b0000;
      @(posedge clk); #1;
      md_en = 1'b0;
   endtask

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] e);
      vec++;
      if (act !== e) begin
         miss++;
         $display("FAIL %s: got %h expected %h", n, act, e);
      end
   endtask

   task automatic wait_tx_done(input int max);
      int n = 0;
      while ((tx_exp_q.size() != 0 || mon_busy) && n < max) begin
         @(posedge clk);
         n++;
      end
      #1;
      vec++;
      if (n >= max) begin
         miss++;
         $display("FAIL tx_timeout: %0d frames still pending after %0d cycles", tx_exp_q.size(), n);
      end
      tick(4);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(CPB);
      end
      uart_rx = stop;
      tick(CPB);
      uart_rx = 1'b1;
   endtask

   initial begin : stim
      rstn = 1'b0; md_en = 1'b0; md_ad = '0; md_we = '0; md_wd = '0; uart_rx = 1'b1;
      tick(3);
      check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_md_rd", md_rd, 32'h0);
      rstn = 1'b1;
      tick(2);
      bus_rd(A_ST, 32'h2, "rst_status");
      bus_rd(A_CT, 32'h0, "rst_ctrl");
      bus_rd(A_RX, 32'h0, "rst_rxdata");
      bus_rd(A_TX, 32'h0, "txdata_write_only");

      // single frame A5
      tx_exp_q.push_back({1'b0, 8'hA5});
      bus_wr(A_TX, 32'hA5, 4'b0001);
      wait_tx_done(300);
      bus_rd(A_ST, 32'h2, "a5_status_empty");

      // five back-to-back pushes, sixth dropped
      for (int i = 1; i <= 5; i++) tx_exp_q.push_back({(i != 1), 8'(i)});
      for (int i = 1; i <= 5; i++) bus_wr(A_TX, 32'(i), 4'b0001);
      bus_wr(A_TX, 32'h06, 4'b0001);
      bus_rd(A_ST, 32'h21, "drop_full_status");
      wait_tx_done(800);
      bus_rd(A_ST, 32'h22, "drop_sticky");
      bus_wr(A_ST, 32'h20, 4'b0001);
      bus_rd(A_ST, 32'h2, "drop_cleared");

      // ignored writes: we[0]=0, and an address outside the window
      bus_wr(A_CT, 32'h7, 4'b1110);
      bus_rd(A_CT, 32'h0, "ctrl_we0_ignored");
      bus_wr(32'h9000_0004, 32'h77, 4'b0001);

      // loopback
      bus_wr(A_CT, 32'h4, 4'b0001);
      bus_rd(A_CT, 32'h4, "ctrl_loopback");
      tx_exp_q.push_back({1'b0, 8'h3C});
      bus_wr(A_TX, 32'h3C, 4'b0001);
      wait_tx_done(300);
      tick(5);
      bus_rd(A_ST, 32'h6, "lb_status");
      bus_rd(A_RX, 32'h3C, "lb_rxdata_1");
      bus_rd(A_RX, 32'h3C, "lb_rxdata_2");
      check("irq_masked", {31'h0, irq}, 32'h0);
      bus_wr(A_CT, 32'h5, 4'b0001);
      check("irq_rx", {31'h0, irq}, 32'h1);
      bus_wr(A_ST, 32'h4, 4'b0001);
      bus_rd(A_ST, 32'h2, "lb_ack");
      check("irq_rx_acked", {31'h0, irq}, 32'h0);
      bus_wr(A_CT, 32'h2, 4'b0001);
      check("irq_tx_empty", {31'h0, irq}, 32'h1);
      bus_wr(A_CT, 32'h0, 4'b0001);

      // overrun and framing error from the external line
      send_rx(8'h11, 1'b1);
      tick(2);
      send_rx(8'h22, 1'b1);
      tick(10);
      bus_rd(A_ST, 32'h0E, "overrun_status");
      bus_rd(A_RX, 32'h11, "overrun_rxdata");
      send_rx(8'h55, 1'b0);
      tick(20);
      bus_rd(A_ST, 32'h1E, "frame_err_status");
      bus_rd(A_RX, 32'h11, "frame_err_rxdata");

      // clear all sticky bits, then a one-cycle glitch
      bus_wr(A_ST, 32'h3C, 4'b0001);
      bus_rd(A_ST, 32'h2, "clear_all");
      uart_rx = 1'b0;
      tick(1);
      uart_rx = 1'b1;
      tick(20);
      bus_rd(A_ST, 32'h2, "glitch_status");
      bus_rd(A_RX, 32'h11, "glitch_rxdata");

      // reset in the middle of a TX frame
      bus_wr(A_CT, 32'h2, 4'b0001);
      bus_wr(A_TX, 32'h81, 4'b0001);
      tick(30);
      check("mid_frame_low", {31'h0, uart_tx}, 32'h0);
      rstn = 1'b0;
      #1;
      check("rst_mid_uart_tx", {31'h0, uart_tx}, 32'h1);
      check("rst_mid_md_rd", md_rd, 32'h0);
      check("rst_mid_irq", {31'h0, irq}, 32'h0);
      tick(2);
      rstn = 1'b1;
      tick(2);
      bus_rd(A_ST, 32'h2, "post_rst_status");
      bus_rd(A_RX, 32'h0, "post_rst_rxdata");
      bus_rd(A_CT, 32'h0, "post_rst_ctrl");
      tick(150);

      check("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);
      check("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
